// File: rtl/dmem_pkg.sv
// Shared types and sizing for the data-memory arbiter.
// Beat sequencing serialises one 64-bit access into byte-wide memory cycles.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned BEATS         = 8;
    localparam int unsigned BEAT_W        = $clog2(BEATS);
    localparam int unsigned DATA_W        = 64;
    localparam int unsigned MEM_BYTES_DEF = 1024;
    localparam int unsigned ADDR_W_DEF    = $clog2(MEM_BYTES_DEF);

    // Width of a counter able to hold 0..max_val, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        int unsigned w;
        w = 1;
        while ((64'(1) << w) <= 64'(max_val)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner selection: requester 0 has priority unless
// requester 1 has been starved for STARVE_MAX consecutive grants.
module dmem_arb_pick
    import dmem_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned CNT_W      = cnt_width(STARVE_MAX)
) (
    input  logic             i_m0_req,
    input  logic             i_m1_req,
    input  logic [CNT_W-1:0] i_starve_cnt,
    output logic             o_grant_c,
    output logic             o_sel_m1_c
);

    logic w_force_m1;

    always_comb begin
        w_force_m1 = i_m1_req && (i_starve_cnt == CNT_W'(STARVE_MAX));
        o_grant_c  = i_m0_req | i_m1_req;
        o_sel_m1_c = i_m1_req & (~i_m0_req | w_force_m1);
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a byte-wide data memory; each granted 64-bit
// access is split into eight byte beats followed by a one-cycle done pulse.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned MEM_BYTES  = MEM_BYTES_DEF,
    parameter int unsigned STARVE_MAX = 4,
    localparam int unsigned AW        = $clog2(MEM_BYTES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [DATA_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_done,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [DATA_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_done,
    output logic [AW-1:0]     mem_addr,
    output logic              mem_we,
    output logic              mem_re,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    localparam int unsigned CNT_W = cnt_width(STARVE_MAX);
    localparam int unsigned IDX_W = BEAT_W + 3;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_owner;
    logic                r_we;
    logic [AW-1:0]       r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [BEAT_W-1:0]   r_beat;
    logic [CNT_W-1:0]    r_starve;
    logic [DATA_W-1:0]   r_m0_rdata;
    logic [DATA_W-1:0]   r_m1_rdata;

    logic                w_grant;
    logic                w_sel_m1;
    logic                w_load;
    logic [AW:0]         w_addr_sum;
    logic [AW-1:0]       w_beat_addr;
    logic [IDX_W-1:0]    w_byte_idx;
    logic                w_unused;

    assign w_unused = ^{m0_addr[DATA_W-1:AW], m1_addr[DATA_W-1:AW]};

    dmem_arb_pick #(
        .STARVE_MAX (STARVE_MAX),
        .CNT_W      (CNT_W)
    ) u_pick (
        .i_m0_req     (m0_req),
        .i_m1_req     (m1_req),
        .i_starve_cnt (r_starve),
        .o_grant_c    (w_grant),
        .o_sel_m1_c   (w_sel_m1)
    );

    // Beat address wraps modulo MEM_BYTES, also for non-power-of-two depths.
    always_comb begin
        w_addr_sum  = {1'b0, r_addr} + (AW+1)'(r_beat);
        w_beat_addr = (w_addr_sum >= (AW+1)'(MEM_BYTES))
                    ? AW'(w_addr_sum - (AW+1)'(MEM_BYTES))
                    : AW'(w_addr_sum);
        w_byte_idx  = {r_beat, 3'b000};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        mem_addr    = '0;
        mem_we      = 1'b0;
        mem_re      = 1'b0;
        mem_wdata   = '0;
        m0_done     = 1'b0;
        m1_done     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_grant) begin
                    w_load      = 1'b1;
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                mem_addr  = w_beat_addr;
                mem_we    = r_we;
                mem_re    = ~r_we;
                mem_wdata = r_wdata[w_byte_idx +: 8];
                if (r_beat == BEAT_W'(BEATS - 1)) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                m0_done     = ~r_owner;
                m1_done     = r_owner;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Grant latching, starvation tracking and beat datapath.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owner    <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_beat     <= '0;
            r_starve   <= '0;
            r_m0_rdata <= '0;
            r_m1_rdata <= '0;
        end else if (w_load) begin
            r_owner <= w_sel_m1;
            r_we    <= w_sel_m1 ? m1_we : m0_we;
            r_addr  <= w_sel_m1 ? m1_addr[AW-1:0] : m0_addr[AW-1:0];
            r_wdata <= w_sel_m1 ? m1_wdata : m0_wdata;
            r_beat  <= '0;
            if (w_sel_m1 || !m1_req) begin
                r_starve <= '0;
            end else if (r_starve != CNT_W'(STARVE_MAX)) begin
                r_starve <= r_starve + CNT_W'(1);
            end
        end else if (r_state == BUSY) begin
            r_beat <= r_beat + BEAT_W'(1);
            if (!r_we) begin
                if (r_owner) begin
                    r_m1_rdata[w_byte_idx +: 8] <= mem_rdata;
                end else begin
                    r_m0_rdata[w_byte_idx +: 8] <= mem_rdata;
                end
            end
        end
    end

    assign m0_rdata = r_m0_rdata;
    assign m1_rdata = r_m1_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: expected completions are queued at issue
// time and checked by an independent monitor whenever a done pulse appears.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m0_req = 1'b0, m0_we = 1'b0;
    logic [63:0] m0_addr = '0, m0_wdata = '0, m0_rdata;
    logic        m0_done;
    logic        m1_req = 1'b0, m1_we = 1'b0;
    logic [63:0] m1_addr = '0, m1_wdata = '0, m1_rdata;
    logic        m1_done;
    logic [9:0]  mem_addr;
    logic        mem_we, mem_re;
    logic [7:0]  mem_wdata, mem_rdata;

    logic [7:0]  mem [0:1023] = '{default: 8'h00};

    typedef struct {
        bit          owner;
        logic [63:0] r0;
        logic [63:0] r1;
    } exp_t;

    exp_t        sb_q[$];
    logic [63:0] exp_r0 = '0;
    logic [63:0] exp_r1 = '0;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_rdata  (m0_rdata),
        .m0_done   (m0_done),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_rdata  (m1_rdata),
        .m1_done   (m1_done),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Byte-wide memory: combinational read, write on the rising edge.
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input bit owner, input bit is_read, input logic [63:0] val);
        exp_t e;
        if (is_read) begin
            if (owner) exp_r1 = val;
            else       exp_r0 = val;
        end
        e.owner = owner;
        e.r0    = exp_r0;
        e.r1    = exp_r1;
        sb_q.push_back(e);
    endtask

    task automatic run_txn(input bit port, input bit we, input logic [63:0] addr,
                           input logic [63:0] wdata, input logic [63:0] exp_rd);
        bit seen;
        @(posedge clk); #1;
        if (port) begin m1_we = we; m1_addr = addr; m1_wdata = wdata; end
        else      begin m0_we = we; m0_addr = addr; m0_wdata = wdata; end
        push_exp(port, !we, exp_rd);
        if (port) m1_req = 1'b1;
        else      m0_req = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = port ? m1_done : m0_done;
        end
        check("txn_done_seen", 64'(seen), 64'd1);
        m0_req = 1'b0;
        m1_req = 1'b0;
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (m0_done || m1_done) begin
            check("done_overlap", 64'(m0_done & m1_done), 64'd0);
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: m0_done=%0b m1_done=%0b, none expected (t=%0t)",
                         m0_done, m1_done, $time);
            end else begin
                e = sb_q.pop_front();
                check("grant_owner", 64'(m1_done), 64'(e.owner));
                check("sb_m0_rdata", m0_rdata, e.r0);
                check("sb_m1_rdata", m1_rdata, e.r1);
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: time limit reached at t=%0t", $time);
        $fatal(1);
    end

    initial begin : stim
        logic [63:0] wd;
        logic [7:0]  wrap_exp [8];
        logic [7:0]  abort_exp [4];
        int          activity;
        int          cnt;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_m0_rdata", m0_rdata, 64'd0);
        check("rst_m1_rdata", m1_rdata, 64'd0);
        check("rst_done", 64'({m0_done, m1_done}), 64'd0);
        check("rst_mem_ctl", 64'({mem_we, mem_re}), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        activity = 0;
        repeat (20) begin
            @(negedge clk);
            if (mem_we || mem_re || m0_done || m1_done) activity++;
        end
        check("idle_activity", 64'(activity), 64'd0);

        // m0 write with cycle-exact beat checks
        wd = 64'h8877665544332211;
        @(posedge clk); #1;
        m0_we = 1'b1; m0_addr = 64'h10; m0_wdata = wd;
        push_exp(1'b0, 1'b0, 64'd0);
        m0_req = 1'b1;
        @(posedge clk);
        for (int b = 0; b < 8; b++) begin
            @(negedge clk);
            check("wr_mem_we", 64'(mem_we), 64'd1);
            check("wr_mem_re", 64'(mem_re), 64'd0);
            check("wr_mem_addr", 64'(mem_addr), 64'(16 + b));
            check("wr_mem_wdata", 64'(mem_wdata), 64'(wd[8*b +: 8]));
            check("wr_no_early_done", 64'(m0_done), 64'd0);
        end
        @(negedge clk);
        check("wr_done_cycle", 64'(m0_done), 64'd1);
        m0_req = 1'b0;
        @(negedge clk);
        check("wr_done_one_cycle", 64'(m0_done), 64'd0);
        check("wr_idle_mem_we", 64'(mem_we), 64'd0);

        // m0 read-back
        run_txn(1'b0, 1'b0, 64'h10, 64'd0, 64'h8877665544332211);

        // m1 write across the top of memory
        run_txn(1'b1, 1'b1, 64'd1020, 64'h0102030405060708, 64'd0);
        wrap_exp = '{8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
        for (int i = 0; i < 8; i++) begin
            check("wrap_mem_byte", 64'(mem[(1020 + i) % 1024]), 64'(wrap_exp[i]));
        end
        run_txn(1'b1, 1'b0, 64'd1020, 64'd0, 64'h0102030405060708);

        // Starvation: both held high; reset first so the counter starts at 0
        @(posedge clk); #1;
        reset = 1'b1;
        exp_r0 = '0;
        exp_r1 = '0;
        @(posedge clk); #1;
        reset = 1'b0;
        m0_we = 1'b0; m0_addr = 64'h10;
        m1_we = 1'b0; m1_addr = 64'd1020;
        for (int i = 0; i < 4; i++) push_exp(1'b0, 1'b1, 64'h8877665544332211);
        push_exp(1'b1, 1'b1, 64'h0102030405060708);
        push_exp(1'b0, 1'b1, 64'h8877665544332211);
        m0_req = 1'b1;
        m1_req = 1'b1;
        cnt = 0;
        for (int i = 0; i < 100 && cnt < 6; i++) begin
            @(negedge clk);
            if (m0_done || m1_done) cnt++;
            if (m1_done) m1_req = 1'b0;
            if (cnt == 6) m0_req = 1'b0;
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        check("starve_done_count", 64'(cnt), 64'd6);

        // Reset during beat 3 of a write aborts it
        @(posedge clk); #1;
        m0_we = 1'b1; m0_addr = 64'h100; m0_wdata = 64'h8182838485868788;
        m0_req = 1'b1;
        @(posedge clk);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        m0_req = 1'b0;
        exp_r0 = '0;
        exp_r1 = '0;
        #1;
        check("abort_mem_we", 64'(mem_we), 64'd0);
        check("abort_mem_addr", 64'(mem_addr), 64'd0);
        check("abort_m0_rdata", m0_rdata, 64'd0);
        check("abort_m1_rdata", m1_rdata, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        abort_exp = '{8'h88, 8'h87, 8'h86, 8'h00};
        for (int i = 0; i < 4; i++) begin
            check("abort_mem_byte", 64'(mem[256 + i]), 64'(abort_exp[i]));
        end
        run_txn(1'b0, 1'b0, 64'h100, 64'd0, 64'h0000000000868788);

        @(negedge clk);
        check("sb_queue_empty", 64'(sb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
